// File: rtl/seq_restoring_divider_pkg.sv
// Shared multiplier/divider package.
// Holds the divider FSM state encoding and the default operand width used by
// the sequential divider and its single-step datapath.
package seq_restoring_divider_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_restoring_divider_step.sv
// div_restore_step: one combinational restoring-division iteration.
// Shifts {partial remainder, quotient} left by one, trial-subtracts the
// divisor magnitude and keeps the difference (quotient LSB = 1) when it is
// non-negative, otherwise restores the shifted remainder (quotient LSB = 0).
// Ports:
//   rem_in  [WIDTH-1:0]  partial remainder (always < dvs)
//   quo_in  [WIDTH-1:0]  partial quotient / remaining dividend bits
//   dvs     [WIDTH-1:0]  divisor magnitude (non-zero)
//   rem_out [WIDTH-1:0]  next partial remainder
//   quo_out [WIDTH-1:0]  next partial quotient
module div_restore_step
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  // The shifted remainder needs WIDTH+1 bits: with an unsigned divisor near
  // 2^WIDTH the doubled remainder can exceed the WIDTH-bit range.
  logic [WIDTH:0] shifted;
  logic           fits;

  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    fits    = (shifted >= {1'b0, dvs});
    // When the subtraction fits, the true difference is < dvs < 2^WIDTH, so
    // the low WIDTH bits of the modular difference are exact.
    rem_out = fits ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle restoring divider, signed or unsigned.
// One quotient bit per clock in CALC, then a FIX cycle applies the operand
// signs and publishes the result with a one-cycle done pulse.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                request, sampled only while idle
//   is_signed            1 = two's-complement operands (captured with start)
//   dividend, divisor    operands (captured with start)
//   busy                 high while in CALC or FIX
//   done                 one-cycle pulse, results valid while high
//   quotient, remainder  results, held until the next done
//   div_by_zero          set when the last completed divisor was zero
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // Two's-complement negate of a magnitude when neg is set. Negating the
  // magnitude 2^(WIDTH-1) wraps to the most-negative value, which is what
  // makes most-negative / -1 come out without a special path.
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                  input logic             neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dz_q, dz_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem, step_quo;

  always_comb begin
    a_neg = is_signed & dividend[WIDTH-1];
    b_neg = is_signed & divisor[WIDTH-1];
    a_mag = apply_sign(dividend, a_neg);
    b_mag = apply_sign(divisor, b_neg);
  end

  div_restore_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    dvd_d         = dvd_q;
    q_neg_d       = q_neg_q;
    r_neg_d       = r_neg_q;
    dz_d          = dz_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          dvs_d   = b_mag;
          rem_d   = '0;
          quo_d   = a_mag;
          cnt_d   = CNT_W'(WIDTH);
          dz_d    = (divisor == '0);
          state_d = (divisor == '0) ? ST_FIX : ST_CALC;
        end
      end

      ST_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
        if (dz_q) begin
          quotient_d    = '1;
          remainder_d   = dvd_q;
          div_by_zero_d = 1'b1;
        end else begin
          // A zero magnitude stays zero after negation, so a quotient is only
          // negative when it is non-zero.
          quotient_d    = apply_sign(quo_q, q_neg_q);
          remainder_d   = apply_sign(rem_q, r_neg_q);
          div_by_zero_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---- control and result registers (reset) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  // ---- iteration datapath registers (reloaded on every accepted start) ----
  always_ff @(posedge clk) begin
    rem_q   <= rem_d;
    quo_q   <= quo_d;
    dvs_q   <= dvs_d;
    dvd_q   <= dvd_d;
    q_neg_q <= q_neg_d;
    r_neg_q <= r_neg_d;
    dz_q    <= dz_d;
  end

  always_comb begin
    busy        = (state_q != ST_IDLE);
    done        = done_q;
    quotient    = quotient_q;
    remainder   = remainder_q;
    div_by_zero = div_by_zero_q;
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Testbench for seq_restoring_divider (WIDTH = 32).
// Expected results come from a reference model and travel through a
// scoreboard queue from the moment a start is driven until done appears.
module tb_seq_restoring_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sbv;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      if (sgn) begin
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
      end else begin
        sa  = longint'({32'b0, a});
        sbv = longint'({32'b0, b});
      end
      e.q  = W'(sa / sbv);
      e.r  = W'(sa % sbv);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Presents one operation for a single clock edge and records its expectation.
  // Returns at the falling edge just after the capture edge.
  task automatic drive_start(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start     = 1'b1;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    sb.push_back(model(sgn, a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done, counting falling edges since the capture edge and how
  // many of the first W samples showed busy.
  task automatic wait_done(output int cycles, output int busy_n, output bit to);
    cycles = 0;
    busy_n = 0;
    to     = 1'b0;
    while (done !== 1'b1) begin
      if (busy === 1'b1 && cycles < W) busy_n++;
      if (cycles >= 60) begin
        to = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b q=%h r=%h dz=%b, required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_signed_basic();
    int   c, bn;
    bit   to;
    exp_t e;
    drive_start(1'b1, 32'd100, 32'd7);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b, required 1", busy);
    end
    wait_done(c, bn, to);
    e = sb.pop_front();
    checks++;
    if (to || c != 33) begin
      errors++;
      $display("FAIL latency_100_7: got %0d cycles (timeout=%0b), required 33", c, to);
    end
    checks++;
    if (bn != 32) begin
      errors++;
      $display("FAIL busy_calc_100_7: busy in %0d of the 32 CALC cycles, required 32", bn);
    end
    checks++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz} || quotient !== 32'd14 || remainder !== 32'd2) begin
      errors++;
      $display("FAIL result_100_7: got q=%h r=%h dz=%b, required q=%h r=%h dz=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dz);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_at_done: got %b, required 0", busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || quotient !== 32'd14) begin
      errors++;
      $display("FAIL done_pulse_hold: done=%b q=%h, required done=0 q=0000000e", done, quotient);
    end
  endtask

  task automatic test_table();
    bit           sg[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] av[8] = '{32'hFFFF_FF9C, 32'd100, 32'h8000_0000, 32'hFFFF_FFFF,
                            32'h8000_0000, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    logic [W-1:0] bv[8] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd2,
                            32'd1, 32'd9, 32'd9, 32'hFFFF_FFFF};
    int   c, bn;
    bit   to;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      drive_start(sg[i], av[i], bv[i]);
      wait_done(c, bn, to);
      e = sb.pop_front();
      checks++;
      if (to || c != 33 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz}) begin
        errors++;
        $display("FAIL table_%0d: %h/%h s=%0b got q=%h r=%h dz=%b lat=%0d, required q=%h r=%h dz=%b lat=33",
                 i, av[i], bv[i], sg[i], quotient, remainder, div_by_zero, c, e.q, e.r, e.dz);
      end
    end
  endtask

  task automatic test_div_zero();
    int   c, bn;
    bit   to;
    exp_t e;
    drive_start(1'b1, 32'h0000_1234, 32'd0);
    wait_done(c, bn, to);
    e = sb.pop_front();
    checks++;
    if (to || c != 1) begin
      errors++;
      $display("FAIL dz_latency: got %0d cycles (timeout=%0b), required 1", c, to);
    end
    checks++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz} ||
        quotient !== 32'hFFFF_FFFF || remainder !== 32'h0000_1234 || div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dz_result: got q=%h r=%h dz=%b, required q=ffffffff r=00001234 dz=1",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_back_to_back();
    int   c, bn;
    bit   to;
    exp_t e;
    @(negedge clk);
    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd10;
    sb.push_back(model(1'b0, 32'd1000, 32'd10));
    @(negedge clk);
    // start stays high with new operands for the whole first operation.
    is_signed = 1'b1;
    dividend  = 32'hFFFF_FFB3;
    divisor   = 32'd5;
    wait_done(c, bn, to);
    e = sb.pop_front();
    checks++;
    if (to || c != 33 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz}) begin
      errors++;
      $display("FAIL b2b_first: got q=%h r=%h dz=%b lat=%0d, required q=%h r=%h dz=%b lat=33",
               quotient, remainder, div_by_zero, c, e.q, e.r, e.dz);
    end
    sb.push_back(model(1'b1, 32'hFFFF_FFB3, 32'd5));
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b after done-cycle start, required 1", busy);
    end
    wait_done(c, bn, to);
    e = sb.pop_front();
    checks++;
    if (to || c != 33 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz}) begin
      errors++;
      $display("FAIL b2b_second: got q=%h r=%h dz=%b lat=%0d, required q=%h r=%h dz=%b lat=33",
               quotient, remainder, div_by_zero, c, e.q, e.r, e.dz);
    end
  endtask

  task automatic test_reset_abort();
    int   c, bn;
    bit   to;
    bit   seen;
    exp_t e;
    @(negedge clk);
    start     = 1'b1;
    is_signed = 1'b1;
    dividend  = 32'd100;
    divisor   = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    // Reset lands at CALC cycle 10, together with a competing start.
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: busy=%b done=%b q=%h r=%h dz=%b, required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst   = 1'b0;
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_done: activity seen after reset=1, required none");
    end
    drive_start(1'b0, 32'd9, 32'd3);
    wait_done(c, bn, to);
    e = sb.pop_front();
    checks++;
    if (to || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz} || quotient !== 32'd3 || remainder !== 32'd0) begin
      errors++;
      $display("FAIL after_abort_9_3: got q=%h r=%h dz=%b, required q=00000003 r=00000000 dz=0",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_random();
    int           c, bn;
    bit           to, sg;
    logic [W-1:0] a, b;
    exp_t         e;
    for (int i = 0; i < 10; i++) begin
      sg = 1'($urandom_range(1, 0));
      a  = $urandom;
      b  = $urandom >> $urandom_range(31, 0);
      if (i == 5) b = '0;
      drive_start(sg, a, b);
      wait_done(c, bn, to);
      e = sb.pop_front();
      checks++;
      if (to || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz}) begin
        errors++;
        $display("FAIL random_%0d: %h/%h s=%0b got q=%h r=%h dz=%b, required q=%h r=%h dz=%b",
                 i, a, b, sg, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_signed_basic();
    test_table();
    test_div_zero();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_restoring_divider.md
SEQ_RESTORING_DIVIDER -- requirements
Module: seq_restoring_divider

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  request; sampled only in IDLE.
REQ-005 is_signed  in  1  1 = two's-complement operands, 0 = unsigned; captured with start.
REQ-006 dividend  in  WIDTH  numerator; captured with start.
REQ-007 divisor  in  WIDTH  denominator; captured with start.
REQ-008 busy  out  1  high in CALC and FIX states.
REQ-009 done  out  1  one-cycle pulse; results valid while high.
REQ-010 quotient  out  WIDTH  result quotient; holds until next done.
REQ-011 remainder  out  WIDTH  result remainder; holds until next done.
REQ-012 div_by_zero  out  1  flag for the last completed operation; holds until next done.

Function
REQ-013 FSM states SHALL be IDLE, CALC and FIX.
REQ-014 IDLE with start=1 at edge E0 SHALL capture operands, sign flags and operand magnitudes, load the iteration counter with WIDTH, and go to CALC; if divisor==0, go directly to FIX.
REQ-015 CALC SHALL perform one restoring step per cycle: shift {partial remainder, quotient} left by 1, trial-subtract |divisor|, and set the quotient LSB to 1 and keep the difference if the result is non-negative.
REQ-016 After WIDTH CALC cycles (edge E0+WIDTH), the FSM SHALL enter FIX.
REQ-017 FIX SHALL, on the next edge, register the sign-corrected quotient and remainder, set done=1 for exactly one cycle, and return to IDLE; done is high after edge E0+WIDTH+1.
REQ-018 Divide-by-zero SHALL make done high after edge E0+1 with quotient = all ones, remainder = dividend and div_by_zero=1.
REQ-019 Signed mode SHALL truncate toward zero: quotient negative iff operand signs differ and quotient non-zero; remainder sign equals dividend sign; remainder magnitude < |divisor|.
REQ-020 Signed overflow (most-negative / -1) SHALL need no special path: quotient = most-negative value, remainder = 0, div_by_zero=0.
REQ-021 Internal partial-remainder arithmetic SHALL be WIDTH+1 bits so that the magnitude 2^(WIDTH-1) and the unsigned full range never overflow.
REQ-022 start while busy=1 SHALL be ignored; the in-flight operation is unaffected.
REQ-023 start asserted in the done cycle SHALL be accepted (FSM is back in IDLE).
REQ-024 Operand input changes after the capture edge SHALL have no effect on the in-flight result.
REQ-025 quotient, remainder and div_by_zero SHALL change only on the edge that raises done.

Reset
REQ-026 rst=1 SHALL force IDLE and set busy, done, quotient, remainder, div_by_zero and the counter to 0 at the next edge.
REQ-027 rst during CALC or FIX SHALL abort the operation with no done pulse; rst has priority over start.

Structure
REQ-028 The state enumeration and the default WIDTH constant SHALL live in the shared multiplier/divider package.
REQ-029 The single-bit shift/trial-subtract/select step SHALL be the combinational sub-module div_restore_step, instantiated once.

Verification
REQ-030 Signed 100 / 7: quotient=14, remainder=2, done exactly 33 cycles after the start edge, busy high for 32 cycles.
REQ-031 Signed -100 / 7: quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2); signed 100 / -7: quotient=-14, remainder=2.
REQ-032 Signed 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0, div_by_zero=0.
REQ-033 Unsigned 0xFFFFFFFF / 2: quotient=0x7FFFFFFF, remainder=1; signed 0x1234 / 0: quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1, done one cycle after the start edge.
REQ-034 Back-to-back: second start held high throughout the first operation is ignored until the done cycle and is then accepted; second done arrives 33 cycles later.
REQ-035 rst asserted at CALC cycle 10: no done; all outputs 0 next cycle; a following 9 / 3 operation gives quotient=3, remainder=0.
